// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transfer sequencer: default sizing
// constants and the sequencer FSM state encoding.
`timescale 1ns/1ps
package spi_seq_pkg;

  // Default word width, FIFO depth and start-timeout budget.
  localparam int SEQ_BITS          = 5;
  localparam int SEQ_DEPTH         = 4;
  localparam int SEQ_START_TIMEOUT = 16;

  // Sequencer FSM states. The encoding is fixed so state values stay
  // readable in waveforms and in older code that uses plain vectors.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_CAPTURE   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/spi_xfer_sequencer_if.sv
// Bus bundle between the host, the sequencer and the SPI master.
// The slave modport is the sequencer's view; master is the other side.
`timescale 1ns/1ps
interface spi_xfer_sequencer_if
  import spi_seq_pkg::*;
#(
  parameter int BITS  = SEQ_BITS,
  parameter int DEPTH = SEQ_DEPTH
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Host write side
  logic            i_wr_valid;
  logic [BITS-1:0] i_wr_data;
  logic            o_wr_ready;
  // Host read side
  logic            o_rd_valid;
  logic [BITS-1:0] o_rd_data;
  logic            i_rd_ready;
  // SPI master side
  logic [BITS-1:0] o_m_data;
  logic            o_m_send;
  logic            i_m_busy;
  logic [BITS-1:0] i_m_data;
  // Status
  logic [CW-1:0]   o_tx_count;
  logic [CW-1:0]   o_rx_count;
  logic            o_timeout_err;

  modport slave (
    input  i_wr_valid, i_wr_data, i_rd_ready, i_m_busy, i_m_data,
    output o_wr_ready, o_rd_valid, o_rd_data, o_m_data, o_m_send,
           o_tx_count, o_rx_count, o_timeout_err
  );

  modport master (
    output i_wr_valid, i_wr_data, i_rd_ready, i_m_busy, i_m_data,
    input  o_wr_ready, o_rd_valid, o_rd_data, o_m_data, o_m_send,
           o_tx_count, o_rx_count, o_timeout_err
  );

endinterface

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with combinational head read. Push is ignored when
// full and pop is ignored when empty, so callers may drive requests freely.
`timescale 1ns/1ps
module spi_sync_fifo #(
  parameter int BITS  = 5,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [BITS-1:0] push_data,
  input  logic            pop,
  output logic [BITS-1:0] pop_data,
  output logic            full,
  output logic            empty,
  output logic [AW:0]     count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            do_push;
  logic            do_pop;

  assign full     = (count_reg == FULL_CNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage write; left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Moves host words from a TX FIFO through an SPI master one at a time and
// collects the received words in an RX FIFO. A launch that the master never
// acknowledges is abandoned after START_TIMEOUT cycles and flagged.
`timescale 1ns/1ps
module spi_xfer_sequencer
  import spi_seq_pkg::*;
#(
  parameter int BITS          = SEQ_BITS,
  parameter int DEPTH         = SEQ_DEPTH,
  parameter int START_TIMEOUT = SEQ_START_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  spi_xfer_sequencer_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(START_TIMEOUT - 1);

  localparam logic [1:0] IDLE      = 2'(ST_IDLE);
  localparam logic [1:0] LAUNCH    = 2'(ST_LAUNCH);
  localparam logic [1:0] WAIT_DONE = 2'(ST_WAIT_DONE);
  localparam logic [1:0] CAPTURE   = 2'(ST_CAPTURE);

  logic [1:0]      state_reg, state_next;
  logic [TW-1:0]   to_cnt_reg, to_cnt_next;
  logic [BITS-1:0] hold_reg, hold_next;
  logic            err_reg, err_next;

  logic            tx_pop, rx_push;
  logic [BITS-1:0] tx_head, rx_head;
  logic            tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0]   tx_count, rx_count;

  spi_sync_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (bus.i_wr_valid),
    .push_data (bus.i_wr_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  spi_sync_fifo #(.BITS(BITS), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (rx_push),
    .push_data (bus.i_m_data),
    .pop       (bus.i_rd_ready),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // Next-state logic. A launch is only started when the RX FIFO has room,
  // which is what lets CAPTURE push without checking for full.
  always_comb begin
    state_next  = state_reg;
    to_cnt_next = to_cnt_reg;
    hold_next   = hold_reg;
    err_next    = err_reg;
    tx_pop      = 1'b0;
    rx_push     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!tx_empty && !rx_full && !bus.i_m_busy) begin
          state_next  = LAUNCH;
          hold_next   = tx_head;
          to_cnt_next = '0;
          tx_pop      = 1'b1;
        end
      end
      LAUNCH: begin
        if (bus.i_m_busy) begin
          state_next = WAIT_DONE;
        end else if (to_cnt_reg == TO_LAST) begin
          // Master never started: drop the word and flag it.
          state_next = IDLE;
          err_next   = 1'b1;
        end else begin
          to_cnt_next = to_cnt_reg + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.i_m_busy) state_next = CAPTURE;
      end
      CAPTURE: begin
        rx_push    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, timeout counter, held word and sticky error flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      to_cnt_reg <= '0;
      hold_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      to_cnt_reg <= to_cnt_next;
      hold_reg   <= hold_next;
      err_reg    <= err_next;
    end
  end

  // Send is decoded straight from state so reset drops it at once.
  assign bus.o_m_send      = (state_reg == LAUNCH);
  assign bus.o_m_data      = hold_reg;
  assign bus.o_timeout_err = err_reg;
  assign bus.o_wr_ready    = !tx_full;
  assign bus.o_rd_valid    = !rx_empty;
  assign bus.o_rd_data     = rx_head;
  assign bus.o_tx_count    = tx_count;
  assign bus.o_rx_count    = rx_count;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Directed bench for spi_xfer_sequencer with a simple echoing SPI slave.
`timescale 1ns/1ps
module tb_spi_xfer_sequencer;

  localparam int BITS  = 5;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_xfer_sequencer_if #(.BITS(BITS), .DEPTH(DEPTH)) sif ();

  spi_xfer_sequencer #(.BITS(BITS), .DEPTH(DEPTH), .START_TIMEOUT(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (sif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic            slave_en   = 1'b0;
  logic            slave_hold = 1'b0;
  logic [BITS-1:0] slave_mask = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave model: on seeing send, go busy for three cycles, then return the
  // sent word XOR slave_mask. Otherwise busy follows slave_hold.
  initial begin
    logic [BITS-1:0] lat;
    sif.i_m_busy = 1'b0;
    sif.i_m_data = '0;
    forever begin
      @(negedge clk);
      if (slave_en && sif.o_m_send) begin
        lat = sif.o_m_data ^ slave_mask;
        sif.i_m_busy = 1'b1;
        repeat (3) @(negedge clk);
        sif.i_m_data = lat;
        sif.i_m_busy = 1'b0;
      end else begin
        sif.i_m_busy = slave_hold;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic host_write(input logic [BITS-1:0] d);
    int w = 0;
    while (!sif.o_wr_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_val("wr_ready", sif.o_wr_ready, 1);
    sif.i_wr_valid = 1'b1;
    sif.i_wr_data  = d;
    @(negedge clk);
    sif.i_wr_valid = 1'b0;
    $display("write 0x%02h", d);
  endtask

  task automatic host_read(input logic [BITS-1:0] exp, input string tag);
    int w = 0;
    while (!sif.o_rd_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_val({tag, "_valid"}, sif.o_rd_valid, 1);
    check_val({tag, "_data"}, sif.o_rd_data, exp);
    $display("read  0x%02h (%s)", sif.o_rd_data, tag);
    sif.i_rd_ready = 1'b1;
    @(negedge clk);
    sif.i_rd_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int send_cnt;
    int w;
    logic [BITS-1:0] md;

    rst            = 1'b1;
    sif.i_wr_valid = 1'b0;
    sif.i_wr_data  = '0;
    sif.i_rd_ready = 1'b0;
    #1;
    check_val("rst_send",    sif.o_m_send, 0);
    check_val("rst_mdata",   sif.o_m_data, 0);
    check_val("rst_err",     sif.o_timeout_err, 0);
    check_val("rst_wrready", sif.o_wr_ready, 1);
    check_val("rst_rdvalid", sif.o_rd_valid, 0);
    check_val("rst_txcnt",   sif.o_tx_count, 0);
    check_val("rst_rxcnt",   sif.o_rx_count, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single transfer with a pure echo.
    slave_en = 1'b1;
    slave_mask = '0;
    host_write(5'b10110);
    send_cnt = 0;
    md = '0;
    repeat (12) begin
      if (sif.o_m_send) begin
        send_cnt++;
        md = sif.o_m_data;
      end
      @(negedge clk);
    end
    check_val("t1_send_cycles", send_cnt, 1);
    check_val("t1_mdata", md, 5'b10110);
    check_val("t1_rxcnt", sif.o_rx_count, 1);
    check_val("t1_txcnt", sif.o_tx_count, 0);
    host_read(5'b10110, "t1_rx");
    check_val("t1_rxcnt_after", sif.o_rx_count, 0);

    // Burst of four while the master is held busy, then drained.
    slave_mask = 5'h0A;
    slave_hold = 1'b1;
    @(negedge clk);
    host_write(5'h01);
    host_write(5'h02);
    host_write(5'h03);
    host_write(5'h04);
    check_val("t2_wrready_full", sif.o_wr_ready, 0);
    check_val("t2_txcnt_full", sif.o_tx_count, 4);
    sif.i_wr_valid = 1'b1;
    sif.i_wr_data  = 5'h05;
    @(negedge clk);
    sif.i_wr_valid = 1'b0;
    check_val("t2_txcnt_reject", sif.o_tx_count, 4);
    slave_hold = 1'b0;
    idle(40);
    check_val("t2_rxcnt", sif.o_rx_count, 4);
    check_val("t2_txcnt", sif.o_tx_count, 0);
    host_read(5'h0B, "t2_rx0");
    host_read(5'h08, "t2_rx1");
    host_read(5'h09, "t2_rx2");
    host_read(5'h0E, "t2_rx3");

    // RX full stalls the sequencer with one word left in TX.
    slave_mask = '0;
    host_write(5'h11);
    host_write(5'h12);
    host_write(5'h13);
    host_write(5'h14);
    host_write(5'h15);
    idle(60);
    check_val("t3_rxcnt_full", sif.o_rx_count, 4);
    check_val("t3_txcnt_held", sif.o_tx_count, 1);
    check_val("t3_send_idle", sif.o_m_send, 0);
    host_read(5'h11, "t3_rx0");
    idle(15);
    check_val("t3_rxcnt_refill", sif.o_rx_count, 4);
    check_val("t3_txcnt_done", sif.o_tx_count, 0);
    host_read(5'h12, "t3_rx1");
    host_read(5'h13, "t3_rx2");
    host_read(5'h14, "t3_rx3");
    host_read(5'h15, "t3_rx4");
    check_val("t3_rxcnt_empty", sif.o_rx_count, 0);

    // Start timeout: master never goes busy.
    slave_en = 1'b0;
    host_write(5'h1F);
    send_cnt = 0;
    repeat (30) begin
      if (sif.o_m_send) send_cnt++;
      @(negedge clk);
    end
    check_val("t4_send_cycles", send_cnt, 16);
    check_val("t4_err", sif.o_timeout_err, 1);
    check_val("t4_txcnt", sif.o_tx_count, 0);
    check_val("t4_rxcnt", sif.o_rx_count, 0);
    check_val("t4_rdvalid", sif.o_rd_valid, 0);
    slave_en = 1'b1;
    host_write(5'h07);
    idle(12);
    host_read(5'h07, "t4_rx_after");
    check_val("t4_err_sticky", sif.o_timeout_err, 1);

    // Reset while the master is busy with a transfer.
    host_write(5'h0C);
    host_write(5'h0D);
    w = 0;
    do begin
      @(negedge clk);
      #1;
      w++;
    end while (!(sif.i_m_busy && !sif.o_m_send) && w < 20);
    check_val("t5_reach_wait", sif.i_m_busy && !sif.o_m_send, 1);
    check_val("t5_txcnt_pre", sif.o_tx_count, 1);
    check_val("t5_mdata_pre", sif.o_m_data, 5'h0C);
    rst = 1'b1;
    #1;
    check_val("t5_send", sif.o_m_send, 0);
    check_val("t5_txcnt", sif.o_tx_count, 0);
    check_val("t5_rxcnt", sif.o_rx_count, 0);
    check_val("t5_err", sif.o_timeout_err, 0);
    check_val("t5_mdata", sif.o_m_data, 0);
    check_val("t5_wrready", sif.o_wr_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(20);
    check_val("t5_rxcnt_after", sif.o_rx_count, 0);
    check_val("t5_rdvalid_after", sif.o_rd_valid, 0);
    check_val("t5_send_after", sif.o_m_send, 0);

    // Push and pop on the same edge keep the TX count steady.
    slave_mask = 5'h15;
    slave_hold = 1'b1;
    @(negedge clk);
    host_write(5'h03);
    host_write(5'h1C);
    check_val("t6_txcnt_pre", sif.o_tx_count, 2);
    @(posedge clk);
    #1;
    slave_hold = 1'b0;
    @(negedge clk);
    sif.i_wr_valid = 1'b1;
    sif.i_wr_data  = 5'h09;
    @(negedge clk);
    sif.i_wr_valid = 1'b0;
    $display("write 0x%02h (with launch pop)", 5'h09);
    check_val("t6_txcnt_same", sif.o_tx_count, 2);
    check_val("t6_send", sif.o_m_send, 1);
    idle(40);
    check_val("t6_txcnt_end", sif.o_tx_count, 0);
    host_read(5'h16, "t6_rx0");
    host_read(5'h09, "t6_rx1");
    host_read(5'h1C, "t6_rx2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
